axi_mem_responder: RTL and testbench

AXI_MEM_RESPONDER -- requirements
Module: axi_mem_responder

---
 rtl/axi_pkg.sv | 10 +
 rtl/axi_mem_responder_if.sv | 24 ++
 rtl/axi_mem_regfile.sv | 26 ++
 rtl/axi_mem_responder.sv | 111 +++++++++++
 tb/tb_axi_mem_responder.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_pkg.sv
// axi_pkg: AXI response codes, responder FSM state encodings and the address-window check
package axi_pkg;
  localparam logic [1:0] OKAY = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_DATA} r_state_e;
  function automatic logic in_window(input logic [31:0] addr, input logic [31:0] base, input int depth);
    return addr >= base && ((addr - base) >> 2) < 32'(depth);
  endfunction
endpackage

// File: rtl/axi_mem_responder_if.sv
// axi_mem_responder_if: AXI write/read channel bundle with master and slave views
interface axi_mem_responder_if;
  logic [31:0] awaddr;
  logic [3:0] awlen;
  logic awvalid, awready;
  logic [31:0] wdata;
  logic wvalid, wlast, wready;
  logic [1:0] bresp;
  logic bvalid, bready;
  logic [31:0] araddr;
  logic [3:0] arlen;
  logic arvalid, arready;
  logic [31:0] rdata;
  logic [1:0] rresp;
  logic rlast, rvalid, rready;
  modport master (
    output awaddr, awlen, awvalid, wdata, wvalid, wlast, bready, araddr, arlen, arvalid, rready,
    input awready, wready, bresp, bvalid, arready, rdata, rresp, rlast, rvalid
  );
  modport slave (
    input awaddr, awlen, awvalid, wdata, wvalid, wlast, bready, araddr, arlen, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/axi_mem_regfile.sv
// axi_mem_regfile: DEPTH x 32 storage, one synchronous write port, one registered read port, reset-clear
module axi_mem_regfile #(
  parameter int DEPTH = 16,
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1
) (
  input  logic          aclk,
  input  logic          areset,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic          re,
  input  logic          rok,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);
  logic [31:0] mem [DEPTH];
  always_ff @(posedge aclk or negedge areset) begin
    if (!areset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rdata <= '0;
    end else begin
      if (we) mem[waddr] <= wdata;
      if (re) rdata <= rok ? mem[raddr] : '0;
    end
  end
endmodule

// File: rtl/axi_mem_responder.sv
// axi_mem_responder: AXI burst memory slave with independent write and read FSMs over a small regfile
module axi_mem_responder
  import axi_pkg::*;
#(
  parameter int          DEPTH = 16,
  parameter logic [31:0] BASE  = 32'h0000_0000
) (
  input logic aclk,
  input logic areset,
  axi_mem_responder_if.slave bus
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  w_state_e w_state;
  r_state_e r_state;
  logic [31:0] w_addr, r_addr, r_next;
  logic [3:0] w_len, w_cnt, r_len, r_cnt;
  logic w_err, w_hs, w_ok, w_bad, r_ok, r_re;
  assign w_hs = bus.wready && bus.wvalid;
  assign w_ok = in_window(w_addr, BASE, DEPTH);
  assign w_bad = !w_ok || (bus.wlast != (w_cnt == w_len));
  // the read port always looks one beat ahead so the next word is ready with no bubble
  assign r_next = r_state == R_IDLE ? bus.araddr & ~32'd3 : r_addr + 32'd4;
  assign r_ok = in_window(r_next, BASE, DEPTH);
  assign r_re = (bus.arready && bus.arvalid) || (bus.rvalid && bus.rready && !bus.rlast);
  axi_mem_regfile #(.DEPTH(DEPTH)) u_regfile (
    .aclk(aclk), .areset(areset),
    .we(w_hs && w_ok), .waddr(AW'((w_addr - BASE) >> 2)), .wdata(bus.wdata),
    .re(r_re), .rok(r_ok), .raddr(AW'((r_next - BASE) >> 2)), .rdata(bus.rdata)
  );
  always_ff @(posedge aclk or negedge areset) begin
    if (!areset) begin
      w_state <= W_IDLE;
      bus.awready <= 1'b0;
      bus.wready <= 1'b0;
      bus.bvalid <= 1'b0;
      bus.bresp <= OKAY;
      w_addr <= '0;
      w_len <= '0;
      w_cnt <= '0;
      w_err <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: if (bus.awready && bus.awvalid) begin
          w_state <= W_DATA;
          bus.awready <= 1'b0;
          bus.wready <= 1'b1;
          w_addr <= bus.awaddr & ~32'd3;
          w_len <= bus.awlen;
          w_cnt <= '0;
          w_err <= 1'b0;
        end else bus.awready <= 1'b1;
        W_DATA: if (w_hs) begin
          w_addr <= w_addr + 32'd4;
          w_cnt <= w_cnt + 4'd1;
          w_err <= w_err || w_bad;
          if (w_cnt == w_len) begin
            w_state <= W_RESP;
            bus.wready <= 1'b0;
            bus.bvalid <= 1'b1;
            bus.bresp <= (w_err || w_bad) ? SLVERR : OKAY;
          end
        end
        W_RESP: if (bus.bready) begin
          w_state <= W_IDLE;
          bus.bvalid <= 1'b0;
          bus.awready <= 1'b1;
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end
  always_ff @(posedge aclk or negedge areset) begin
    if (!areset) begin
      r_state <= R_IDLE;
      bus.arready <= 1'b0;
      bus.rvalid <= 1'b0;
      bus.rlast <= 1'b0;
      bus.rresp <= OKAY;
      r_addr <= '0;
      r_len <= '0;
      r_cnt <= '0;
    end else begin
      case (r_state)
        R_IDLE: if (bus.arready && bus.arvalid) begin
          r_state <= R_DATA;
          bus.arready <= 1'b0;
          bus.rvalid <= 1'b1;
          bus.rlast <= bus.arlen == 4'd0;
          bus.rresp <= r_ok ? OKAY : SLVERR;
          r_addr <= r_next;
          r_len <= bus.arlen;
          r_cnt <= '0;
        end else bus.arready <= 1'b1;
        R_DATA: if (bus.rready) begin
          if (bus.rlast) begin
            r_state <= R_IDLE;
            bus.rvalid <= 1'b0;
            bus.rlast <= 1'b0;
            bus.arready <= 1'b1;
          end else begin
            r_addr <= r_next;
            r_cnt <= r_cnt + 4'd1;
            bus.rlast <= r_cnt + 4'd1 == r_len;
            bus.rresp <= r_ok ? OKAY : SLVERR;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi_mem_responder.sv
// tb_axi_mem_responder: scoreboard bench with directed and randomized bursts against a memory model
module tb_axi_mem_responder;
  localparam int DEPTH = 16;
  localparam logic [31:0] BASE = 32'h0000_0000;
  typedef struct packed {logic [31:0] data; logic [1:0] resp; logic last;} rbeat_t;
  logic aclk = 1'b0;
  logic areset = 1'b0;
  axi_mem_responder_if bus();
  axi_mem_responder #(.DEPTH(DEPTH), .BASE(BASE)) dut (.aclk(aclk), .areset(areset), .bus(bus));
  always #5 aclk = ~aclk;

  logic [1:0] bq[$];
  rbeat_t rq[$];
  logic [31:0] model[DEPTH];
  logic [31:0] wbuf[16];
  int n_tests = 0, n_fail = 0, cyc = 0, aw_cyc = 0, ar_cyc = 0, lat_b = -1, rr_mode = 0;
  bit lat_r = 0, rnd_b = 0, held = 0, bv_prev = 0, rv_prev = 0;
  rbeat_t hold_v;

  always @(posedge aclk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit in_mem(input logic [31:0] a);
    return longint'(a) >= longint'(BASE) && longint'(a) < longint'(BASE) + 4 * DEPTH;
  endfunction

  function automatic rbeat_t exp_beat(input logic [31:0] a, input bit last);
    if (in_mem(a)) return rbeat_t'{data: model[int'((a - BASE) / 4)], resp: 2'b00, last: last};
    return rbeat_t'{data: 32'h0, resp: 2'b10, last: last};
  endfunction

  initial begin
    bus.bready = 1'b1;
    bus.rready = 1'b1;
    forever begin
      @(posedge aclk);
      #1;
      bus.rready = rr_mode == 0 ? 1'b1 : rr_mode == 1 ? !bus.rready : 1'($urandom_range(0, 1));
      bus.bready = rnd_b ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  always @(negedge aclk) begin
    if (!areset) held = 0;
    else begin
      if (held && bus.rvalid) chk("r_hold_stable", {bus.rdata, bus.rresp, bus.rlast}, hold_v);
      held = bus.rvalid && !bus.rready;
      hold_v = {bus.rdata, bus.rresp, bus.rlast};
      if (bus.bvalid && !bv_prev && lat_b >= 0) chk("b_latency", 64'(cyc + 1 - aw_cyc), 64'(lat_b + 2));
      if (bus.rvalid && !rv_prev && lat_r) chk("r_latency", 64'(cyc + 1 - ar_cyc), 64'd1);
      if (bus.bvalid && bus.bready) begin
        if (bq.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL b_unexpected: got bresp %0h with no expected response", bus.bresp);
        end else chk("bresp", bus.bresp, bq.pop_front());
      end
      if (bus.rvalid && bus.rready) begin
        if (rq.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL r_unexpected: got rdata %0h with no expected beat", bus.rdata);
        end else chk("rbeat{data,resp,last}", {bus.rdata, bus.rresp, bus.rlast}, rq.pop_front());
      end
    end
    bv_prev = bus.bvalid;
    rv_prev = bus.rvalid;
  end

  task automatic hs(input string name, input int which);
    int t = 0;
    logic r;
    forever begin
      r = which == 0 ? bus.awready : which == 1 ? bus.wready : bus.arready;
      @(posedge aclk);
      if (r) break;
      if (++t > 200) begin
        n_tests++; n_fail++;
        $display("FAIL %s_handshake: got no ready within 200 cycles, required ready", name);
        break;
      end
    end
    #1;
  endtask

  task automatic drain(input string name);
    int t = 0;
    while ((bq.size() != 0 || rq.size() != 0) && t < 500) begin
      @(posedge aclk);
      #1;
      t++;
    end
    chk({"drain_", name}, 64'(bq.size() + rq.size()), 64'd0);
    bq.delete();
    rq.delete();
  endtask

  task automatic do_write(input logic [31:0] addr, input int len, input int wl_at, input bit stall, input bit lat);
    logic [31:0] a;
    bit err;
    a = addr & ~32'd3;
    err = 0;
    for (int i = 0; i <= len; i++)
      if (((i == wl_at) != (i == len)) || !in_mem(a + 32'(4 * i))) err = 1;
    bq.push_back(err ? 2'b10 : 2'b00);
    lat_b = lat ? len : -1;
    bus.awaddr = addr;
    bus.awlen = 4'(len);
    bus.awvalid = 1'b1;
    hs("aw", 0);
    aw_cyc = cyc;
    bus.awvalid = 1'b0;
    for (int i = 0; i <= len; i++) begin
      while (stall && $urandom_range(0, 3) == 0) begin
        @(posedge aclk);
        #1;
      end
      bus.wdata = wbuf[i];
      bus.wlast = i == wl_at;
      bus.wvalid = 1'b1;
      hs("w", 1);
      if (in_mem(a + 32'(4 * i))) model[int'((a + 32'(4 * i) - BASE) / 4)] = wbuf[i];
      bus.wvalid = 1'b0;
      bus.wlast = 1'b0;
    end
    drain("write");
    lat_b = -1;
  endtask

  task automatic do_read(input logic [31:0] addr, input int len, input bit lat);
    logic [31:0] a;
    a = addr & ~32'd3;
    for (int i = 0; i <= len; i++) rq.push_back(exp_beat(a + 32'(4 * i), i == len));
    bus.araddr = addr;
    bus.arlen = 4'(len);
    bus.arvalid = 1'b1;
    hs("ar", 2);
    ar_cyc = cyc;
    lat_r = lat;
    bus.arvalid = 1'b0;
    drain("read");
    lat_r = 0;
  endtask

  initial begin
    int t;
    bus.awaddr = '0; bus.awlen = '0; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0;
    bus.araddr = '0; bus.arlen = '0; bus.arvalid = 1'b0;
    foreach (model[i]) model[i] = '0;
    repeat (2) @(posedge aclk);
    #1;
    chk("reset_outputs", {bus.awready, bus.wready, bus.bvalid, bus.arready, bus.rvalid, bus.rlast,
                          bus.bresp, bus.rresp, bus.rdata}, 64'd0);
    areset = 1'b1;
    @(posedge aclk);
    #1;
    chk("ready_after_release", {bus.awready, bus.arready}, 2'b11);
    wbuf[0] = 32'hDEADBEEF;
    do_write(32'h08, 0, 0, 0, 1);
    do_read(32'h08, 0, 1);
    for (int i = 0; i < 4; i++) wbuf[i] = 32'(i + 1);
    do_write(32'h00, 3, 3, 0, 1);
    rr_mode = 1;
    do_read(32'h00, 3, 1);
    rr_mode = 0;
    wbuf[0] = 32'h5555_0001;
    wbuf[1] = 32'h6666_0002;
    do_write(32'h3C, 1, 1, 0, 0);
    do_read(32'h3C, 1, 0);
    wbuf[0] = 32'h7; wbuf[1] = 32'h8; wbuf[2] = 32'h9;
    do_write(32'h20, 2, 1, 0, 0);
    do_read(32'h20, 2, 0);
    wbuf[0] = 32'hA;
    do_write(32'h14, 0, 0, 0, 0);
    bq.push_back(2'b00);
    bus.awaddr = 32'h14; bus.awlen = 4'd0; bus.awvalid = 1'b1;
    hs("aw", 0);
    bus.awvalid = 1'b0;
    rq.push_back(exp_beat(32'h14, 1));
    bus.wdata = 32'hB; bus.wlast = 1'b1; bus.wvalid = 1'b1;
    bus.araddr = 32'h14; bus.arlen = 4'd0; bus.arvalid = 1'b1;
    chk("collide_same_edge_ready", {bus.wready, bus.arready}, 2'b11);
    @(posedge aclk);
    #1;
    bus.wvalid = 1'b0; bus.wlast = 1'b0; bus.arvalid = 1'b0;
    model[5] = 32'hB;
    drain("collide");
    do_read(32'h14, 0, 0);
    rnd_b = 1;
    rr_mode = 2;
    repeat (25) begin
      int len, wl;
      len = $urandom_range(0, 7);
      wl = $urandom_range(0, 7) == 0 ? $urandom_range(0, len) : len;
      foreach (wbuf[i]) wbuf[i] = $urandom;
      do_write(32'($urandom_range(0, 4 * DEPTH + 16)), len, wl, 1, 0);
      do_read(32'($urandom_range(0, 4 * DEPTH + 16)), $urandom_range(0, 15), 0);
    end
    rnd_b = 0;
    rr_mode = 0;
    for (int i = 0; i < 4; i++) wbuf[i] = $urandom | 32'h1;
    do_write(32'h00, 3, 3, 0, 0);
    for (int i = 0; i < 4; i++) rq.push_back(exp_beat(32'(4 * i), i == 3));
    bus.araddr = 32'h00; bus.arlen = 4'd3; bus.arvalid = 1'b1;
    hs("ar", 2);
    bus.arvalid = 1'b0;
    t = 0;
    while (rq.size() > 2 && t < 50) begin
      @(posedge aclk);
      #1;
      t++;
    end
    chk("mid_burst_reached", 64'(rq.size()), 64'd2);
    areset = 1'b0;
    #1;
    chk("reset_kills_burst", {bus.rvalid, bus.rlast, bus.arready, bus.awready, bus.bvalid, bus.rdata}, 64'd0);
    rq.delete();
    repeat (2) @(posedge aclk);
    #1;
    chk("reset_held_idle", {bus.rvalid, bus.bvalid, bus.wready}, 3'b000);
    areset = 1'b1;
    @(posedge aclk);
    #1;
    chk("ready_after_mid_reset", {bus.awready, bus.arready}, 2'b11);
    foreach (model[i]) model[i] = '0;
    do_read(32'h00, 15, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within 500000 time units");
    $fatal(1);
  end
endmodule
